// File: rtl/flattening_stream_layer.sv
// Flattening stage: gathers NumOfImages feature maps from NumOfInputs lanes into
// ping-pong frame banks and streams each frame out as OutWidth-pixel beats.
module flattening_stream_layer #(
    parameter int unsigned BitSize     = 2,
    parameter int unsigned ImageSize   = 9,
    parameter int unsigned NumOfImages = 4,
    parameter int unsigned NumOfInputs = 2,
    parameter int unsigned OutWidth    = 4
) (
    input  logic                           clk,
    input  logic                           res_n,
    input  logic [NumOfInputs-1:0]         in_valid,
    input  logic [NumOfInputs*BitSize-1:0] in_data,
    output logic                           in_ready,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic                           out_start,
    output logic                           out_last,
    output logic [OutWidth*BitSize-1:0]    out_data
);
    localparam int unsigned Total     = NumOfImages * ImageSize;
    localparam int unsigned NumGroups = (NumOfImages + NumOfInputs - 1) / NumOfInputs;
    localparam int unsigned NumBeats  = (Total + OutWidth - 1) / OutWidth;
    localparam int unsigned CW        = $clog2(ImageSize + 1);
    localparam int unsigned GW        = $clog2(NumGroups + 1);
    localparam int unsigned BW        = $clog2(NumBeats + 1);
    localparam int unsigned AW        = (Total > 1) ? $clog2(Total) : 1;

    typedef enum logic { FILL, WAIT } fill_state_t;
    typedef enum logic { IDLE, DRAIN } drain_state_t;

    fill_state_t        fill_state;
    drain_state_t       drain_state;
    logic [BitSize-1:0] mem [2][Total];
    logic [CW-1:0]      cnt [NumOfInputs];
    logic [AW-1:0]      waddr [NumOfInputs];
    logic [GW-1:0]      group;
    logic [BW-1:0]      beat;
    logic               fill_bank;
    logic               drain_bank;
    logic [1:0]         full;
    logic [1:0]         full_next;
    logic [NumOfInputs-1:0] wr;
    logic               lanes_done;
    logic               frame_done;
    logic               drain_free;
    logic               last_group;

    assign in_ready   = (fill_state == FILL);
    assign last_group = (group == GW'(NumGroups - 1));

    // A group completes in the same cycle as its final write, so a lane
    // counts as done either already or by virtue of this cycle's write.
    always_comb begin
        int unsigned img;
        img        = 0;
        lanes_done = in_ready;
        wr         = '0;
        for (int unsigned l = 0; l < NumOfInputs; l++) begin
            img      = 32'(group) * NumOfInputs + l;
            waddr[l] = AW'(img * ImageSize + 32'(cnt[l]));
            if (img < NumOfImages && cnt[l] != CW'(ImageSize)) begin
                wr[l] = in_valid[l] && in_ready;
                if (!(wr[l] && cnt[l] == CW'(ImageSize - 1)))
                    lanes_done = 1'b0;
            end
        end
        frame_done = lanes_done && last_group;
        drain_free = (drain_state == DRAIN) && out_ready && (beat == BW'(NumBeats - 1));
        full_next  = full;
        if (frame_done) full_next[fill_bank]  = 1'b1;
        if (drain_free) full_next[drain_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            fill_state <= FILL;
            fill_bank  <= 1'b0;
            group      <= '0;
            full       <= '0;
            for (int unsigned l = 0; l < NumOfInputs; l++)
                cnt[l] <= '0;
        end else begin
            full <= full_next;
            for (int unsigned l = 0; l < NumOfInputs; l++) begin
                if (lanes_done)
                    cnt[l] <= '0;
                else if (wr[l])
                    cnt[l] <= cnt[l] + 1'b1;
            end
            if (lanes_done) begin
                if (last_group) begin
                    group     <= '0;
                    fill_bank <= ~fill_bank;
                end else begin
                    group <= group + 1'b1;
                end
            end
            case (fill_state)
                FILL:    if (frame_done && full_next[~fill_bank]) fill_state <= WAIT;
                WAIT:    if (!full_next[fill_bank]) fill_state <= FILL;
                default: fill_state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < NumOfInputs; l++)
            if (wr[l])
                mem[fill_bank][waddr[l]] <= in_data[l*BitSize +: BitSize];
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            drain_state <= IDLE;
            drain_bank  <= 1'b0;
            beat        <= '0;
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            case (drain_state)
                IDLE: begin
                    if (full_next[drain_bank]) begin
                        drain_state <= DRAIN;
                        beat        <= '0;
                        out_valid   <= 1'b1;
                        out_start   <= 1'b1;
                        out_last    <= (NumBeats == 1);
                    end
                end
                DRAIN: begin
                    if (drain_free) begin
                        drain_bank <= ~drain_bank;
                        beat       <= '0;
                        if (full_next[~drain_bank]) begin
                            out_start <= 1'b1;
                            out_last  <= (NumBeats == 1);
                        end else begin
                            drain_state <= IDLE;
                            out_valid   <= 1'b0;
                            out_start   <= 1'b0;
                            out_last    <= 1'b0;
                        end
                    end else if (out_ready) begin
                        beat      <= beat + 1'b1;
                        out_start <= 1'b0;
                        out_last  <= (beat + 1'b1 == BW'(NumBeats - 1));
                    end
                end
                default: drain_state <= IDLE;
            endcase
        end
    end

    // Lowest flattened index sits in the top element; padding reads as zero.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        out_data = '0;
        for (int unsigned e = 0; e < OutWidth; e++) begin
            idx = 32'(beat) * OutWidth + (OutWidth - 1 - e);
            if (out_valid && idx < Total)
                out_data[e*BitSize +: BitSize] = mem[drain_bank][AW'(idx)];
        end
    end
endmodule

// File: tb/tb_flattening_stream_layer.sv
// Bench for flattening_stream_layer: table-driven frame runs checked by a beat
// scoreboard, plus back-to-back, reset-abort and a 3-image configuration.
module tb_flattening_stream_layer;
    localparam int BS    = 2;
    localparam int IS    = 9;
    localparam int NI    = 4;
    localparam int NL    = 2;
    localparam int OW    = 4;
    localparam int DW    = NL * BS;
    localparam int TOT   = NI * IS;
    localparam int NG    = (NI + NL - 1) / NL;
    localparam int NB    = (TOT + OW - 1) / OW;
    localparam int NI_B  = 3;
    localparam int TOT_B = NI_B * IS;
    localparam int NB_B  = (TOT_B + OW - 1) / OW;

    typedef logic [OW*BS-1:0] beat_t;
    typedef struct { beat_t data; logic start; logic last; } exp_beat_t;
    typedef struct { int pat; int l1p; int rmode; int exp_fill; } vec_t;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    logic [NL-1:0] in_valid = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_ready = 1'b0;
    logic          out_valid, out_start, out_last;
    beat_t         out_data;

    logic [NL-1:0] in_valid_b = '0;
    logic [DW-1:0] in_data_b = '0;
    logic          in_ready_b;
    logic          out_ready_b = 1'b1;
    logic          out_valid_b, out_start_b, out_last_b;
    beat_t         out_data_b;

    flattening_stream_layer #(.BitSize(BS), .ImageSize(IS), .NumOfImages(NI),
                              .NumOfInputs(NL), .OutWidth(OW)) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_start(out_start), .out_last(out_last), .out_data(out_data));

    flattening_stream_layer #(.BitSize(BS), .ImageSize(IS), .NumOfImages(NI_B),
                              .NumOfInputs(NL), .OutWidth(OW)) dut_b (
        .clk(clk), .res_n(res_n), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .out_ready(out_ready_b), .out_valid(out_valid_b),
        .out_start(out_start_b), .out_last(out_last_b), .out_data(out_data_b));

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int rmode_g = 4;
    exp_beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic beat_t ref_beat(input logic [BS-1:0] fr [TOT], input int tot, input int b);
        beat_t w = '0;
        for (int k = 0; k < OW; k++) begin
            w = w << BS;
            if (b * OW + k < tot) w[BS-1:0] = fr[b * OW + k];
        end
        return w;
    endfunction

    // out_ready pattern: 0 always high, 1 toggling, 2 random, 4 left to the test
    initial forever begin
        @(posedge clk); #1;
        case (rmode_g)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom);
            default: ;
        endcase
    end

    initial forever begin
        logic stall;
        logic ps, pl;
        beat_t pd;
        exp_beat_t e;
        stall = 1'b0; ps = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                stall = 1'b0;
                continue;
            end
            if (!out_valid) check("idle_data_zero", out_data, 0);
            if (stall) check("stall_hold", {out_valid, out_start, out_last, out_data}, {1'b1, ps, pl, pd});
            if (out_valid && out_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got 0x%0h, want no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_start", out_start, e.start);
                    check("beat_last", out_last, e.last);
                end
            end
            stall = out_valid && !out_ready;
            pd = out_data; ps = out_start; pl = out_last;
        end
    end

    task automatic set_mode(input int m);
        @(posedge clk); #2;
        rmode_g = m;
        if (m == 4) out_ready = 1'b0;
    endtask

    task automatic send_frame(input int pat, input int l1p, output int cycles, output logic pre_valid);
        logic [BS-1:0] fr [TOT];
        int cnt [NL];
        int g, ph, img;
        logic v, done;
        exp_beat_t e;
        for (int i = 0; i < TOT; i++) fr[i] = (pat == 0) ? BS'(i % 4) : BS'($urandom);
        for (int b = 0; b < NB; b++) begin
            e.data = ref_beat(fr, TOT, b);
            e.start = (b == 0);
            e.last = (b == NB - 1);
            exp_q.push_back(e);
        end
        for (int l = 0; l < NL; l++) cnt[l] = 0;
        g = 0; ph = 0; cycles = 0;
        while (g < NG && cycles < 1000) begin
            @(posedge clk); #1;
            for (int l = 0; l < NL; l++) begin
                img = g * NL + l;
                if (l1p == 0) v = 1'($urandom);
                else v = (l == 0) || (ph % l1p == 0);
                in_valid[l] = v;
                if (img < NI && cnt[l] < IS) begin
                    in_data[l*BS +: BS] = fr[img * IS + cnt[l]];
                    if (v && in_ready) cnt[l]++;
                end else begin
                    in_data[l*BS +: BS] = BS'($urandom);
                end
            end
            cycles++; ph++;
            done = 1'b1;
            for (int l = 0; l < NL; l++)
                if (g * NL + l < NI && cnt[l] < IS) done = 1'b0;
            if (done) begin
                g++; ph = 0;
                for (int l = 0; l < NL; l++) cnt[l] = 0;
            end
        end
        if (g < NG) begin
            total++; bad++;
            $display("FAIL fill_timeout: got group %0d, want %0d", g, NG);
        end
        pre_valid = out_valid;
        @(posedge clk); #1;
        in_valid = '0;
    endtask

    task automatic drain_wait(input int target);
        int n = 0;
        while (accepts < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("accept_count", accepts, target);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl [6];
        int cyc, base, k;
        logic pre;
        logic [BS-1:0] frb [TOT];

        tbl[0] = '{0, 1, 0, 18};
        tbl[1] = '{1, 3, 0, 50};
        tbl[2] = '{1, 1, 1, 18};
        tbl[3] = '{1, 2, 2, 34};
        tbl[4] = '{1, 0, 2, 0};
        tbl[5] = '{1, 0, 1, 0};

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        #19 res_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready_b", in_ready_b, 1);

        // 3-image configuration: lane 1 is inactive in group 1
        for (int i = 0; i < TOT; i++) frb[i] = (i < TOT_B) ? BS'($urandom) : '0;
        for (int c = 0; c < 2 * IS; c++) begin
            @(posedge clk); #1;
            for (int l = 0; l < NL; l++) begin
                in_valid_b[l] = 1'b1;
                if ((c / IS) * NL + l < NI_B)
                    in_data_b[l*BS +: BS] = frb[((c / IS) * NL + l) * IS + c % IS];
                else
                    in_data_b[l*BS +: BS] = BS'($urandom);
            end
        end
        @(posedge clk); #1;
        in_valid_b = '0;
        k = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid_b) begin
                if (k < NB_B) begin
                    check("b_beat_data", out_data_b, ref_beat(frb, TOT_B, k));
                    check("b_beat_start", out_start_b, k == 0);
                    check("b_beat_last", out_last_b, k == NB_B - 1);
                end
                k++;
            end
        end
        check("b_beat_count", k, NB_B);

        for (int i = 0; i < 6; i++) begin
            set_mode(tbl[i].rmode);
            base = accepts;
            send_frame(tbl[i].pat, tbl[i].l1p, cyc, pre);
            if (tbl[i].exp_fill != 0) check("fill_cycles", cyc, tbl[i].exp_fill);
            check("valid_before_last_write", pre, 0);
            check("valid_after_last_write", out_valid, 1);
            if (i == 0) begin
                check("first_beat_data", out_data, 8'h1B);
                check("first_beat_start", out_start, 1);
            end
            drain_wait(base + NB);
        end

        // two frames queued behind a stalled sink, then released
        set_mode(4);
        base = accepts;
        send_frame(1, 1, cyc, pre);
        send_frame(1, 1, cyc, pre);
        check("b2b_in_ready_blocked", in_ready, 0);
        check("b2b_valid_held", out_valid, 1);
        check("b2b_start_held", out_start, 1);
        out_ready = 1'b1;
        for (int j = 1; j <= 2 * NB; j++) begin
            @(posedge clk); #1;
            check("b2b_no_bubble", out_valid, j < 2 * NB);
            check("b2b_in_ready", in_ready, j >= NB);
        end
        drain_wait(base + 2 * NB);

        // reset while one frame is stalled and the next is partially filled
        set_mode(4);
        send_frame(1, 1, cyc, pre);
        for (int p = 0; p < 5; p++) begin
            @(posedge clk); #1;
            in_valid = 2'b01;
            in_data = DW'($urandom);
        end
        @(posedge clk); #1;
        in_valid = '0;
        check("pre_reset_valid", out_valid, 1);
        res_n = 1'b0;
        #2;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_data", out_data, 0);
        check("abort_flags", {out_start, out_last}, 0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        res_n = 1'b1;
        set_mode(0);
        base = accepts;
        send_frame(0, 1, cyc, pre);
        check("post_reset_fill_cycles", cyc, 18);
        check("post_reset_first_beat", out_data, 8'h1B);
        drain_wait(base + NB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, want test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
